// File: rtl/pwm_multiphase_pkg.sv
// pwm_multiphase_pkg: shared types and helpers for the multiphase PWM
package pwm_multiphase_pkg;
  localparam int MAX_W = 32;
  localparam int MAX_BUS = MAX_W * 16;
  typedef enum logic [1:0] {DEAD = 2'b00, HS_ON = 2'b01, LS_ON = 2'b10} ins_state_e;
  function automatic logic [MAX_W-1:0] get_slice(input logic [MAX_BUS-1:0] bus, input int i, input int w);
    return MAX_W'(bus >> (i * w)) & ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction
  function automatic logic valid_chan(input logic [MAX_W-1:0] p, t, d, o);
    return (p != '0) && ({t, 1'b0} < {1'b0, p}) && (d <= p) && (o < p);
  endfunction
endpackage

// File: rtl/pwm_multiphase_deadtime_inserter.sv
// deadtime_inserter: turns one raw PWM bit into a complementary gate pair with a dead gap
module deadtime_inserter
  import pwm_multiphase_pkg::*;
#(
  parameter int bitwidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hold,
  input  logic                raw,
  input  logic [bitwidth-1:0] deadtime,
  output logic                highside,
  output logic                lowside
);
  ins_state_e r_state, w_state_nxt;
  logic [bitwidth-1:0] r_tc, w_tc_nxt;
  logic r_prev;
  // state, dead tick counter and last raw sample
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= DEAD;
      r_tc <= '0;
      r_prev <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tc <= w_tc_nxt;
      r_prev <= raw;
    end
  // next state: leave a side on a raw change, wait out the dead ticks, then follow raw
  always_comb begin
    w_state_nxt = r_state;
    w_tc_nxt = r_tc;
    if (hold) begin
      w_state_nxt = DEAD;
      w_tc_nxt = deadtime;
    end else case (r_state)
      HS_ON, LS_ON:
        if (raw != (r_state == HS_ON)) begin
          w_state_nxt = (deadtime == '0) ? (raw ? HS_ON : LS_ON) : DEAD;
          w_tc_nxt = deadtime;
        end
      default:
        if (raw != r_prev) w_tc_nxt = deadtime;
        else if (r_tc <= bitwidth'(1)) w_state_nxt = raw ? HS_ON : LS_ON;
        else w_tc_nxt = r_tc - bitwidth'(1);
    endcase
  end
  assign highside = r_state[0];
  assign lowside = r_state[1];
endmodule

// File: rtl/pwm_multiphase.sv
// pwm_multiphase: shared-counter multi-channel half-bridge PWM with shadow config and fault latch
module pwm_multiphase
  import pwm_multiphase_pkg::*;
#(
  parameter int bitwidth = 8,
  parameter int channel_count = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [bitwidth-1:0]               tick_count_period,
  input  logic [channel_count*bitwidth-1:0] tick_count_highside,
  input  logic [channel_count*bitwidth-1:0] phase_offset,
  input  logic [bitwidth-1:0]               deadtime,
  input  logic [channel_count-1:0]          channel_enable,
  input  logic                              configuration_load_enable,
  output logic                              configuration_valid,
  output logic                              configuration_pending,
  input  logic                              fault,
  input  logic                              fault_clear,
  output logic                              fault_active,
  output logic [bitwidth-1:0]               counter_value,
  output logic                              counter_overflow,
  output logic [channel_count-1:0]          highside_output,
  output logic [channel_count-1:0]          lowside_output
);
  localparam int bus_w = channel_count * bitwidth;
  logic [bitwidth-1:0] r_stg_p, r_stg_t, r_act_p, r_act_t, r_cnt;
  logic [bus_w-1:0] r_stg_d, r_stg_o, r_act_d, r_act_o;
  logic [channel_count-1:0] r_stg_en, r_act_en, r_raw, w_raw_nxt, w_hs, w_ls, w_hold;
  logic r_cfg_valid, r_pending, r_act_valid, r_fs1, r_fs2, r_fault;
  logic w_valid_in, w_ovf, w_apply;
  // validity of the configuration currently on the inputs
  always_comb begin
    w_valid_in = 1'b1;
    for (int k = 0; k < channel_count; k++)
      w_valid_in &= valid_chan(MAX_W'(tick_count_period), MAX_W'(deadtime),
                               get_slice(MAX_BUS'(tick_count_highside), k, bitwidth),
                               get_slice(MAX_BUS'(phase_offset), k, bitwidth));
  end
  assign w_ovf = r_act_valid & (r_cnt == r_act_p - bitwidth'(1));
  assign w_apply = r_pending & (w_ovf | ~r_act_valid);
  // staging and atomic apply at the period boundary; apply always takes the previously staged set
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_stg_p <= '0;
      r_stg_t <= '0;
      r_stg_d <= '0;
      r_stg_o <= '0;
      r_stg_en <= '0;
      r_act_p <= '0;
      r_act_t <= '0;
      r_act_d <= '0;
      r_act_o <= '0;
      r_act_en <= '0;
      r_act_valid <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (configuration_load_enable) begin
        r_stg_p <= tick_count_period;
        r_stg_t <= deadtime;
        r_stg_d <= tick_count_highside;
        r_stg_o <= phase_offset;
        r_stg_en <= channel_enable;
        r_cfg_valid <= w_valid_in;
        r_pending <= w_valid_in;
      end else if (w_apply) r_pending <= 1'b0;
      if (w_apply) begin
        r_act_p <= r_stg_p;
        r_act_t <= r_stg_t;
        r_act_d <= r_stg_d;
        r_act_o <= r_stg_o;
        r_act_en <= r_stg_en;
        r_act_valid <= 1'b1;
      end
    end
  // shared period counter, parked at 0 until a set is active
  always_ff @(posedge clock or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= (~r_act_valid | w_ovf) ? '0 : r_cnt + bitwidth'(1);
  // fault synchroniser and latch; clear only takes effect once the synchronised request is gone
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_fs1 <= 1'b0;
      r_fs2 <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_fs1 <= fault;
      r_fs2 <= r_fs1;
      r_fault <= r_fs2 | (r_fault & ~fault_clear);
    end
  for (genvar j = 0; j < channel_count; j++) begin : g_ch
    logic [bitwidth:0] w_sum, w_loc;
    assign w_sum = {1'b0, r_cnt} + {1'b0, r_act_o[j*bitwidth +: bitwidth]};
    assign w_loc = (w_sum >= {1'b0, r_act_p}) ? w_sum - {1'b0, r_act_p} : w_sum;
    assign w_raw_nxt[j] = w_loc < {1'b0, r_act_d[j*bitwidth +: bitwidth]};
    assign w_hold[j] = ~r_act_valid | ~r_act_en[j] | r_fault;
    deadtime_inserter #(.bitwidth(bitwidth)) u_ins (
      .clock(clock),
      .reset(reset),
      .hold(w_hold[j]),
      .raw(r_raw[j]),
      .deadtime(r_act_t),
      .highside(w_hs[j]),
      .lowside(w_ls[j])
    );
  end
  // raw phase-shifted comparison, one cycle behind the counter
  always_ff @(posedge clock or posedge reset)
    if (reset) r_raw <= '0;
    else r_raw <= w_raw_nxt;
  assign highside_output = w_hs & {channel_count{~r_fault}};
  assign lowside_output = w_ls & {channel_count{~r_fault}};
  assign configuration_valid = r_cfg_valid;
  assign configuration_pending = r_pending;
  assign fault_active = r_fault;
  assign counter_value = r_cnt;
  assign counter_overflow = w_ovf;
endmodule

// File: tb/tb_pwm_multiphase.sv
// tb_pwm_multiphase: directed self-checking bench for pwm_multiphase
module tb_pwm_multiphase;
  logic clock = 1'b0;
  logic reset, load, fault, fclr, cfg_valid, pending, fa, ovf;
  logic [7:0] period, deadtime, cnt;
  logic [23:0] duty, offset;
  logic [2:0] en, hs, ls;
  int s, checks, passes;
  always #5 clock = ~clock;
  pwm_multiphase #(.bitwidth(8), .channel_count(3)) dut (
    .clock(clock),
    .reset(reset),
    .tick_count_period(period),
    .tick_count_highside(duty),
    .phase_offset(offset),
    .deadtime(deadtime),
    .channel_enable(en),
    .configuration_load_enable(load),
    .configuration_valid(cfg_valid),
    .configuration_pending(pending),
    .fault(fault),
    .fault_clear(fclr),
    .fault_active(fa),
    .counter_value(cnt),
    .counter_overflow(ovf),
    .highside_output(hs),
    .lowside_output(ls)
  );
  task automatic step();
    @(posedge clock);
    #1;
    s++;
  endtask
  task automatic goto(input int n);
    while (s < n) step();
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s step %0d observed=%0h expected=%0h", tag, s, obs, exp);
  endtask
  task automatic load_cfg(input int p, t, d0, d1, d2, o0, o1, o2, input logic [2:0] e);
    period = 8'(p);
    deadtime = 8'(t);
    duty = {8'(d2), 8'(d1), 8'(d0)};
    offset = {8'(o2), 8'(o1), 8'(o0)};
    en = e;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask
  function automatic logic [2:0] mdl(input int c, p, d0, d1, d2, o0, o1, o2);
    mdl[0] = ((c + o0) % p) < d0;
    mdl[1] = ((c + o1) % p) < d1;
    mdl[2] = ((c + o2) % p) < d2;
  endfunction
  // zero-deadtime run: gates follow the raw pattern two cycles behind the counter
  task automatic run_t0(input int last, base, p, d0, d1, d2, o0, o1, o2, input logic pend);
    int c;
    logic [2:0] e;
    while (s < last) begin
      step();
      c = (s - base) % p;
      e = mdl((c + p - 2) % p, p, d0, d1, d2, o0, o1, o2);
      chk("t0_cnt", cnt, c);
      chk("t0_ovf", ovf, c == p - 1);
      chk("t0_gates", {hs, ls}, {e, ~e});
      chk("t0_pend", pending, pend);
    end
  endtask
  initial begin
    int c;
    logic h, l;
    logic [5:0] g;
    reset = 1'b1;
    period = '0;
    deadtime = '0;
    duty = '0;
    offset = '0;
    en = '0;
    load = 1'b0;
    fault = 1'b0;
    fclr = 1'b0;
    s = 0;
    checks = 0;
    passes = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gates", {hs, ls}, 6'b0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_pend", pending, 0);
    chk("rst_fault", fa, 0);
    reset = 1'b0;
    s = 0;
    // single channel, P=10 D=4 T=1
    load_cfg(10, 1, 4, 0, 0, 0, 0, 0, 3'b001);
    chk("t1_valid", cfg_valid, 1);
    chk("t1_pend", pending, 1);
    chk("t1_cnt_boot", cnt, 0);
    step();
    chk("t1_pend_applied", pending, 0);
    chk("t1_cnt_start", cnt, 0);
    goto(11);
    while (s < 41) begin
      step();
      c = (s - 2) % 10;
      h = c >= 3 && c <= 5;
      l = c >= 7 || c <= 1;
      chk("t1_cnt", cnt, c);
      chk("t1_ovf", ovf, c == 9);
      chk("t1_gates", {hs, ls}, {2'b00, h, 2'b00, l});
    end
    // three phases, P=12 D=6 O={0,4,8} T=0
    load_cfg(12, 0, 6, 6, 6, 0, 4, 8, 3'b111);
    chk("t2_pend", pending, 1);
    goto(51);
    chk("t2_pend_wait", pending, 1);
    chk("t2_ovf_wait", ovf, 1);
    step();
    chk("t2_pend_done", pending, 0);
    chk("t2_cnt_wrap", cnt, 0);
    goto(63);
    run_t0(87, 52, 12, 6, 6, 6, 0, 4, 8, 1'b0);
    // rejected sets: 2T == P, then D > P
    load_cfg(10, 5, 6, 6, 6, 0, 0, 0, 3'b111);
    chk("t3_valid_dt", cfg_valid, 0);
    chk("t3_pend_dt", pending, 0);
    chk("t3_cnt_dt", cnt, 0);
    load_cfg(10, 1, 11, 6, 6, 0, 0, 0, 3'b111);
    chk("t3_valid_duty", cfg_valid, 0);
    chk("t3_pend_duty", pending, 0);
    chk("t3_cnt_duty", cnt, 1);
    run_t0(111, 52, 12, 6, 6, 6, 0, 4, 8, 1'b0);
    // atomic duty change 3 -> 7 staged mid-period
    load_cfg(12, 0, 3, 3, 3, 0, 4, 8, 3'b111);
    chk("t4_valid", cfg_valid, 1);
    chk("t4_pend", pending, 1);
    goto(135);
    run_t0(141, 124, 12, 3, 3, 3, 0, 4, 8, 1'b0);
    load_cfg(12, 0, 7, 7, 7, 0, 4, 8, 3'b111);
    chk("t4_pend_mid", pending, 1);
    run_t0(147, 124, 12, 3, 3, 3, 0, 4, 8, 1'b1);
    run_t0(149, 124, 12, 3, 3, 3, 0, 4, 8, 1'b0);
    run_t0(171, 124, 12, 7, 7, 7, 0, 4, 8, 1'b0);
    // boundary duties D=P / D=0 with T=2
    load_cfg(8, 2, 8, 0, 8, 0, 0, 0, 3'b111);
    goto(191);
    while (s < 199) begin
      step();
      c = (s - 184) % 8;
      chk("t5_cnt", cnt, c);
      chk("t5_ovf", ovf, c == 7);
      chk("t5_gates", {hs, ls}, 6'b101_010);
    end
    load_cfg(8, 2, 0, 8, 0, 0, 0, 0, 3'b111);
    for (int k = 200; k <= 219; k++) begin
      if (k > 200) step();
      g = s < 210 ? 6'b101_010 : s < 212 ? 6'b000_000 : 6'b010_101;
      chk("t5_sw_cnt", cnt, (s - 184) % 8);
      chk("t5_sw_gates", {hs, ls}, g);
      chk("t5_sw_pend", pending, s < 208);
    end
    // fault latch, ignored clear, clear after release
    fault = 1'b1;
    step();
    chk("t6_gates_s1", {hs, ls}, 6'b010_101);
    chk("t6_fa_s1", fa, 0);
    step();
    chk("t6_gates_s2", {hs, ls}, 6'b010_101);
    step();
    chk("t6_fa_set", fa, 1);
    chk("t6_gates_off", {hs, ls}, 6'b0);
    chk("t6_cnt_run", cnt, 6);
    fclr = 1'b1;
    step();
    chk("t6_clr_ignored", fa, 1);
    fclr = 1'b0;
    fault = 1'b0;
    step();
    chk("t6_fa_hold", fa, 1);
    chk("t6_gates_hold", {hs, ls}, 6'b0);
    chk("t6_cnt_hold", cnt, 0);
    step();
    chk("t6_fa_sync", fa, 1);
    fclr = 1'b1;
    step();
    chk("t6_fa_clr", fa, 0);
    chk("t6_gates_d1", {hs, ls}, 6'b0);
    fclr = 1'b0;
    step();
    chk("t6_gates_d2", {hs, ls}, 6'b0);
    step();
    chk("t6_gates_resume", {hs, ls}, 6'b010_101);
    chk("t6_cnt_resume", cnt, 4);
    // reset while running
    reset = 1'b1;
    #1;
    chk("t7_gates", {hs, ls}, 6'b0);
    chk("t7_cnt", cnt, 0);
    chk("t7_ovf", ovf, 0);
    chk("t7_valid", cfg_valid, 0);
    chk("t7_pend", pending, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("t7_cnt_idle", cnt, 0);
      chk("t7_gates_idle", {hs, ls}, 6'b0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
